// File: rtl/i2c_cmd_sequencer_if.sv
// Command-side and transmitter-side signals of the I2C command sequencer.
// The sequencer connects through the slave modport; its environment uses master.
interface i2c_cmd_sequencer_if #(
    parameter int unsigned FIFO_DEPTH = 8
);
    localparam int unsigned LevelW = $clog2(FIFO_DEPTH) + 1;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [6:0]        cmd_dev;
    logic [7:0]        cmd_reg;
    logic [7:0]        cmd_data;
    logic              tx_start;
    logic [6:0]        tx_dev;
    logic [7:0]        tx_reg;
    logic [7:0]        tx_data;
    logic              tx_done;
    logic              tx_nack;
    logic              seq_idle;
    logic              err_pulse;
    logic [7:0]        err_count;
    logic [LevelW-1:0] fifo_level;

    modport slave (
        input  cmd_valid, cmd_dev, cmd_reg, cmd_data, tx_done, tx_nack,
        output cmd_ready, tx_start, tx_dev, tx_reg, tx_data, seq_idle, err_pulse, err_count,
               fifo_level
    );

    modport master (
        output cmd_valid, cmd_dev, cmd_reg, cmd_data, tx_done, tx_nack,
        input  cmd_ready, tx_start, tx_dev, tx_reg, tx_data, seq_idle, err_pulse, err_count,
               fifo_level
    );
endinterface

// File: rtl/i2c_cmd_sequencer.sv
// Buffers camera register writes and feeds them one at a time to the I2C transmitter,
// with a bus-free gap after each transaction, retry on NACK/timeout and an abandon counter.
module i2c_cmd_sequencer #(
    parameter int unsigned FIFO_DEPTH     = 8,
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned GAP_CYCLES     = 1000,
    parameter int unsigned TIMEOUT_CYCLES = 200000
) (
    input logic                sys_clkp,
    input logic                sys_rstn,
    i2c_cmd_sequencer_if.slave bus
);
    localparam int unsigned PtrW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned LevelW  = PtrW + 1;
    localparam int unsigned ToW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned GapW    = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES - 1) : 1;
    localparam int unsigned RetryW  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int unsigned ToLast  = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    // The cycle that leaves WAIT counts as the first gap cycle, so GAP itself lasts one less.
    localparam int unsigned GapLast = (GAP_CYCLES > 1) ? GAP_CYCLES - 2 : 0;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StGap} state_e;

    state_e              state_q, state_d;
    logic [22:0]         mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [LevelW-1:0]   level_q, level_d;
    logic [ToW-1:0]      to_cnt_q, to_cnt_d;
    logic [GapW-1:0]     gap_cnt_q, gap_cnt_d;
    logic [RetryW-1:0]   retry_q, retry_d;
    logic                ready_q, idle_q, tx_start_q, err_q;
    logic [7:0]          err_cnt_q;
    logic [6:0]          tx_dev_q;
    logic [7:0]          tx_reg_q, tx_data_q;
    logic [22:0]         head;
    logic                push, pop, latch, abandon;

    assign head = mem_q[rd_ptr_q];
    assign push = bus.cmd_valid && ready_q;

    always_comb begin
        state_d   = state_q;
        to_cnt_d  = to_cnt_q;
        gap_cnt_d = gap_cnt_q;
        retry_d   = retry_q;
        pop       = 1'b0;
        latch     = 1'b0;
        abandon   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (level_q != '0) begin
                    latch   = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                to_cnt_d = '0;
                state_d  = StWait;
            end
            StWait: begin
                // tx_done is checked first so it wins over a simultaneous timeout.
                if (bus.tx_done && !bus.tx_nack) begin
                    pop       = 1'b1;
                    retry_d   = '0;
                    gap_cnt_d = '0;
                    state_d   = StGap;
                end else if (bus.tx_done || to_cnt_q == ToW'(ToLast)) begin
                    gap_cnt_d = '0;
                    state_d   = StGap;
                    if (retry_q < RetryW'(MAX_RETRY)) begin
                        retry_d = retry_q + 1'b1;
                    end else begin
                        pop     = 1'b1;
                        abandon = 1'b1;
                        retry_d = '0;
                    end
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            StGap: begin
                if (gap_cnt_q == GapW'(GapLast)) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign level_d = level_q + LevelW'(push) - LevelW'(pop);

    always_ff @(posedge sys_clkp) begin
        if (!sys_rstn) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            to_cnt_q   <= '0;
            gap_cnt_q  <= '0;
            retry_q    <= '0;
            ready_q    <= 1'b1;
            idle_q     <= 1'b1;
            tx_start_q <= 1'b0;
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
            tx_dev_q   <= '0;
            tx_reg_q   <= '0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            to_cnt_q   <= to_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            retry_q    <= retry_d;
            ready_q    <= (level_d != LevelW'(FIFO_DEPTH));
            idle_q     <= (level_d == '0) && (state_d == StIdle);
            tx_start_q <= (state_q == StIssue);
            err_q      <= abandon;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (abandon && err_cnt_q != 8'hff) err_cnt_q <= err_cnt_q + 1'b1;
            if (latch) begin
                tx_dev_q  <= head[22:16];
                tx_reg_q  <= head[15:8];
                tx_data_q <= head[7:0];
            end
        end
    end

    always_ff @(posedge sys_clkp) begin
        if (push) mem_q[wr_ptr_q] <= {bus.cmd_dev, bus.cmd_reg, bus.cmd_data};
    end

    assign bus.cmd_ready  = ready_q;
    assign bus.seq_idle   = idle_q;
    assign bus.tx_start   = tx_start_q;
    assign bus.tx_dev     = tx_dev_q;
    assign bus.tx_reg     = tx_reg_q;
    assign bus.tx_data    = tx_data_q;
    assign bus.err_pulse  = err_q;
    assign bus.err_count  = err_cnt_q;
    assign bus.fifo_level = level_q;
endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Bench for i2c_cmd_sequencer: timestamp-based reference model checked every cycle,
// plus directed scenarios with hand-computed timing and count expectations.
module tb_i2c_cmd_sequencer;
    localparam int D = 8;
    localparam int MR = 3;
    localparam int G = 8;
    localparam int T = 100;

    logic sys_clkp = 1'b0;
    logic sys_rstn = 1'b0;
    always #5 sys_clkp = ~sys_clkp;

    i2c_cmd_sequencer_if #(.FIFO_DEPTH(D)) bus ();

    i2c_cmd_sequencer #(
        .FIFO_DEPTH    (D),
        .MAX_RETRY     (MR),
        .GAP_CYCLES    (G),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .sys_clkp(sys_clkp),
        .sys_rstn(sys_rstn),
        .bus     (bus)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad < 40) $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s at cycle %0d: got no event, expected one within bound", name, cyc);
    endtask

    // Reference model: command queue plus timestamps of issue, resolution and gap end.
    logic [22:0] mq[$];
    bit          m_ok = 0, busy = 0, m_err = 0;
    int          s_at = -1, free_at = 0, tries = 0, m_cnt = 0;
    logic [22:0] m_tx = '0;
    logic        exp_ready, exp_idle, exp_start, exp_err;
    int          exp_level;

    initial forever begin
        bit was_ready, had_head;
        @(posedge sys_clkp);
        cyc++;
        if (!sys_rstn) begin
            mq.delete();
            busy = 0; s_at = -1; free_at = cyc; tries = 0; m_cnt = 0; m_err = 0;
            m_tx = '0; m_ok = 1;
        end else if (m_ok) begin
            m_err = 0;
            was_ready = mq.size() < D;
            had_head = mq.size() > 0;
            if (busy) begin
                if (cyc - 1 >= s_at && (bus.tx_done || cyc - 1 == s_at + T - 1)) begin
                    busy = 0;
                    free_at = cyc - 1 + G;
                    if (bus.tx_done && !bus.tx_nack) begin
                        void'(mq.pop_front());
                        tries = 0;
                    end else if (tries < MR) begin
                        tries++;
                    end else begin
                        void'(mq.pop_front());
                        tries = 0;
                        m_err = 1;
                        if (m_cnt < 255) m_cnt++;
                    end
                end
            end else if (free_at <= cyc - 1 && had_head) begin
                busy = 1;
                s_at = cyc + 1;
                m_tx = mq[0];
            end
            if (bus.cmd_valid && was_ready) mq.push_back({bus.cmd_dev, bus.cmd_reg, bus.cmd_data});
        end
        exp_level = mq.size();
        exp_ready = mq.size() < D;
        exp_idle = (mq.size() == 0) && !busy && (free_at <= cyc);
        exp_start = (s_at == cyc);
        exp_err = m_err;
    end

    int start_cycs[$];
    int err_cycs[$];

    initial forever begin
        @(negedge sys_clkp);
        if (m_ok) begin
            chk("cmd_ready", 32'(bus.cmd_ready), 32'(exp_ready));
            chk("fifo_level", 32'(bus.fifo_level), 32'(exp_level));
            chk("seq_idle", 32'(bus.seq_idle), 32'(exp_idle));
            chk("tx_start", 32'(bus.tx_start), 32'(exp_start));
            chk("err_pulse", 32'(bus.err_pulse), 32'(exp_err));
            chk("err_count", 32'(bus.err_count), 32'(m_cnt));
            chk("tx_dev", 32'(bus.tx_dev), 32'(m_tx[22:16]));
            chk("tx_reg", 32'(bus.tx_reg), 32'(m_tx[15:8]));
            chk("tx_data", 32'(bus.tx_data), 32'(m_tx[7:0]));
        end
        if (bus.tx_start === 1'b1) start_cycs.push_back(cyc);
        if (bus.err_pulse === 1'b1) err_cycs.push_back(cyc);
    end

    // Transmitter stand-in: 0 = stalled, 1 = ACK after resp_delay, 2 = NACK after resp_delay.
    int resp_mode = 0;
    int resp_delay = 1;
    int pend = 0;
    bit manual_done = 0;

    initial forever begin
        @(negedge sys_clkp);
        bus.tx_done = 1'b0;
        bus.tx_nack = 1'b0;
        if (manual_done) begin
            bus.tx_done = 1'b1;
            manual_done = 0;
        end else if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                bus.tx_done = 1'b1;
                bus.tx_nack = (resp_mode == 2);
            end
        end
        if (bus.tx_start === 1'b1 && resp_mode != 0) pend = resp_delay;
    end

    task automatic push(input logic [22:0] c, output int acc);
        bit ok;
        ok = 0;
        acc = -1;
        @(negedge sys_clkp);
        {bus.cmd_dev, bus.cmd_reg, bus.cmd_data} = c;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 3000 && !ok; i++) begin
            if (bus.cmd_ready) ok = 1;
            @(negedge sys_clkp);
        end
        bus.cmd_valid = 1'b0;
        if (ok) acc = cyc;
        else bound_fail("push_accept");
    endtask

    task automatic wait_start(output int c);
        bit seen;
        seen = 0;
        c = -1;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge sys_clkp);
            if (bus.tx_start) begin
                seen = 1;
                c = cyc;
            end
        end
        if (!seen) bound_fail("wait_tx_start");
    endtask

    task automatic wait_idle(output int c);
        bit seen;
        seen = 0;
        c = -1;
        for (int i = 0; i < 4000 && !seen; i++) begin
            @(negedge sys_clkp);
            if (bus.seq_idle) begin
                seen = 1;
                c = cyc;
            end
        end
        if (!seen) bound_fail("wait_seq_idle");
    endtask

    initial begin
        int acc, s, c;
        bit got;
        bus.cmd_valid = 1'b0;
        bus.cmd_dev = '0;
        bus.cmd_reg = '0;
        bus.cmd_data = '0;
        bus.tx_done = 1'b0;
        bus.tx_nack = 1'b0;
        repeat (3) @(negedge sys_clkp);
        sys_rstn = 1'b1;
        chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_idle", 32'(bus.seq_idle), 32'd1);
        chk("rst_level", 32'(bus.fifo_level), 32'd0);
        chk("rst_err_count", 32'(bus.err_count), 32'd0);
        chk("rst_tx_start", 32'(bus.tx_start), 32'd0);

        // Single write, ACK after 50 cycles.
        resp_mode = 1; resp_delay = 50;
        start_cycs.delete(); err_cycs.delete();
        push({7'h3C, 8'h12, 8'h80}, acc);
        wait_start(s);
        chk("t1_issue_latency", 32'(s), 32'(acc + 2));
        chk("t1_tx_dev", 32'(bus.tx_dev), 32'h3C);
        chk("t1_tx_reg", 32'(bus.tx_reg), 32'h12);
        chk("t1_tx_data", 32'(bus.tx_data), 32'h80);
        wait_idle(c);
        chk("t1_idle_cycle", 32'(c), 32'(s + 50 + G));
        chk("t1_starts", 32'(start_cycs.size()), 32'd1);
        chk("t1_err_count", 32'(bus.err_count), 32'd0);

        // NACK on every attempt: 1 + MAX_RETRY issues, then abandon.
        resp_mode = 2; resp_delay = 1;
        start_cycs.delete(); err_cycs.delete();
        push({7'h10, 8'h34, 8'h56}, acc);
        wait_idle(c);
        chk("t2_starts", 32'(start_cycs.size()), 32'd4);
        chk("t2_err_pulses", 32'(err_cycs.size()), 32'd1);
        chk("t2_err_count", 32'(bus.err_count), 32'd1);
        chk("t2_level", 32'(bus.fifo_level), 32'd0);
        if (start_cycs.size() == 4 && err_cycs.size() == 1) begin
            for (int i = 1; i < 4; i++) chk("t2_retry_spacing", 32'(start_cycs[i] - start_cycs[i-1]), 32'd11);
            chk("t2_err_after_start", 32'(err_cycs[0] - start_cycs[3]), 32'd2);
        end

        // Stalled transmitter: every attempt times out; second command follows the gap.
        resp_mode = 0;
        start_cycs.delete(); err_cycs.delete();
        push({7'h21, 8'h01, 8'hAA}, acc);
        push({7'h22, 8'h02, 8'hBB}, acc);
        wait_idle(c);
        chk("t4_starts", 32'(start_cycs.size()), 32'd8);
        chk("t4_err_pulses", 32'(err_cycs.size()), 32'd2);
        chk("t4_err_count", 32'(bus.err_count), 32'd3);
        if (start_cycs.size() == 8 && err_cycs.size() == 2) begin
            chk("t4_timeout_retry", 32'(start_cycs[1] - start_cycs[0]), 32'(T + G + 1));
            chk("t4_err_after_start", 32'(err_cycs[0] - start_cycs[3]), 32'(T));
            chk("t4_next_issue", 32'(start_cycs[4] - err_cycs[0]), 32'(G + 1));
        end

        // Fill the FIFO with the transmitter stalled; ninth offer waits for the first pop.
        for (int i = 0; i < 8; i++) push({7'(7'h30 + i), 8'(i), 8'(8'hA0 + i)}, acc);
        chk("t3_level_full", 32'(bus.fifo_level), 32'd8);
        chk("t3_ready_full", 32'(bus.cmd_ready), 32'd0);
        {bus.cmd_dev, bus.cmd_reg, bus.cmd_data} = {7'h40, 8'h99, 8'h77};
        bus.cmd_valid = 1'b1;
        repeat (20) @(negedge sys_clkp);
        chk("t3_level_held", 32'(bus.fifo_level), 32'd8);
        manual_done = 1;
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge sys_clkp);
            if (bus.cmd_ready) got = 1;
        end
        if (!got) bound_fail("t3_ready_after_pop");
        chk("t3_level_after_pop", 32'(bus.fifo_level), 32'd7);
        @(negedge sys_clkp);
        bus.cmd_valid = 1'b0;
        chk("t3_level_refill", 32'(bus.fifo_level), 32'd8);

        // Reset in the middle of a WAIT with a full queue.
        wait_start(s);
        repeat (3) @(negedge sys_clkp);
        sys_rstn = 1'b0;
        @(negedge sys_clkp);
        sys_rstn = 1'b1;
        chk("t5_level", 32'(bus.fifo_level), 32'd0);
        chk("t5_tx_start", 32'(bus.tx_start), 32'd0);
        chk("t5_err_count", 32'(bus.err_count), 32'd0);
        chk("t5_tx_dev", 32'(bus.tx_dev), 32'd0);
        manual_done = 1;
        repeat (4) @(negedge sys_clkp);
        chk("t5_level_after_done", 32'(bus.fifo_level), 32'd0);
        chk("t5_idle_after_done", 32'(bus.seq_idle), 32'd1);

        // 256 abandoned commands: counter saturates, pulses keep firing.
        resp_mode = 2; resp_delay = 1;
        start_cycs.delete(); err_cycs.delete();
        for (int i = 0; i < 256; i++) push({7'(i), 8'(i), 8'(~i)}, acc);
        wait_idle(c);
        chk("t6_err_count_sat", 32'(bus.err_count), 32'd255);
        chk("t6_err_pulses", 32'(err_cycs.size()), 32'd256);
        chk("t6_starts", 32'(start_cycs.size()), 32'd1024);

        repeat (2) @(negedge sys_clkp);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
